// File: rtl/jtframe_vtimer_prog.sv
// Runtime-programmable video timing generator.
// H/V counters, blanking, sync, init strobes, render-ahead line and flip
// coordinates. Geometry lives in a CPU-writable shadow set that is copied to
// the active set atomically when the frame wraps.
module jtframe_vtimer_prog #(
  parameter int HW         = 9,
  parameter int VW         = 9,
  parameter int HCNT_START = 0,
  parameter int HCNT_END   = 383,
  parameter int HB_START   = 256,
  parameter int HB_END     = 16,
  parameter int HS_START   = 304,
  parameter int HS_END     = 336,
  parameter int VCNT_START = 0,
  parameter int VCNT_END   = 263,
  parameter int VB_START   = 240,
  parameter int VB_END     = 16,
  parameter int VS_START   = 248,
  parameter int VS_END     = 251
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pxl_cen,
  input  logic                             flip,
  input  logic                             cfg_we,
  input  logic [3:0]                       cfg_sel,
  input  logic [((HW > VW) ? HW : VW)-1:0] cfg_data,
  output logic [HW-1:0]                    H,
  output logic [VW-1:0]                    vdump,
  output logic [VW-1:0]                    vrender,
  output logic [HW-1:0]                    hf,
  output logic [VW-1:0]                    vf,
  output logic                             Hinit,
  output logic                             Vinit,
  output logic                             LHBL,
  output logic                             LVBL,
  output logic                             HS,
  output logic                             VS,
  output logic [7:0]                       frame_cnt
);

  localparam int DW = (HW > VW) ? HW : VW;
  localparam int NREG = 12;

  // Register map shared by the shadow and active sets
  localparam int I_HCNT_START = 0;
  localparam int I_HCNT_END   = 1;
  localparam int I_HB_START   = 2;
  localparam int I_HB_END     = 3;
  localparam int I_HS_START   = 4;
  localparam int I_HS_END     = 5;
  localparam int I_VCNT_START = 6;
  localparam int I_VCNT_END   = 7;
  localparam int I_VB_START   = 8;
  localparam int I_VB_END     = 9;
  localparam int I_VS_START   = 10;
  localparam int I_VS_END     = 11;

  localparam logic [DW-1:0] P_INIT [NREG] = '{
    DW'(HCNT_START), DW'(HCNT_END), DW'(HB_START), DW'(HB_END),
    DW'(HS_START),   DW'(HS_END),   DW'(VCNT_START), DW'(VCNT_END),
    DW'(VB_START),   DW'(VB_END),   DW'(VS_START),   DW'(VS_END)
  };

  logic [DW-1:0] r_shadow [NREG];
  logic [DW-1:0] r_active [NREG];
  logic [DW-1:0] w_eff    [NREG];

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_vdump;
  logic          r_lhbl;
  logic          r_lvbl;
  logic          r_hs;
  logic          r_vs;
  logic [7:0]    r_frame_cnt;

  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_commit;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_hinit;

  // Wrap at the programmed end, or at all-ones so a bad end<start setting
  // can never stall the counters.
  assign w_h_wrap = (r_h == r_active[I_HCNT_END][HW-1:0]) || (&r_h);
  assign w_v_wrap = (r_vdump == r_active[I_VCNT_END][VW-1:0]) || (&r_vdump);
  assign w_commit = w_h_wrap && w_v_wrap;

  // On the commit cycle the freshly committed geometry already decides the
  // first position of the new frame and the edge decodes that land on it.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_eff
      assign w_eff[gi] = w_commit ? r_shadow[gi] : r_active[gi];
    end
  endgenerate

  assign w_h_next = w_h_wrap ? w_eff[I_HCNT_START][HW-1:0] : r_h + HW'(1);
  assign w_v_next = !w_h_wrap ? r_vdump :
                    (w_v_wrap ? w_eff[I_VCNT_START][VW-1:0] : r_vdump + VW'(1));

  // Shadow writes ignore pxl_cen; commit copies the pre-write shadow values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_shadow[k] <= P_INIT[k];
        r_active[k] <= P_INIT[k];
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (pxl_cen && w_commit) r_active[k] <= r_shadow[k];
        if (cfg_we && cfg_sel == 4'(k)) r_shadow[k] <= cfg_data;
      end
    end
  end

  // Counters, blanking, sync and frame counter advance once per pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= HW'(HCNT_START);
      r_vdump     <= VW'(VCNT_START);
      r_lhbl      <= 1'b0;
      r_lvbl      <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else if (pxl_cen) begin
      r_h     <= w_h_next;
      r_vdump <= w_v_next;
      if (w_h_next == w_eff[I_HB_START][HW-1:0]) r_lhbl <= 1'b0;
      else if (w_h_next == w_eff[I_HB_END][HW-1:0]) r_lhbl <= 1'b1;
      if (w_h_next == w_eff[I_HS_START][HW-1:0]) r_hs <= 1'b1;
      else if (w_h_next == w_eff[I_HS_END][HW-1:0]) r_hs <= 1'b0;
      if (w_h_wrap) begin
        if (w_v_next == w_eff[I_VB_START][VW-1:0]) r_lvbl <= 1'b0;
        else if (w_v_next == w_eff[I_VB_END][VW-1:0]) r_lvbl <= 1'b1;
      end
      // VS edges are aligned to the HS rising point of the sync lines
      if (w_h_next == w_eff[I_HS_START][HW-1:0]) begin
        if (w_v_next == w_eff[I_VS_START][VW-1:0]) r_vs <= 1'b1;
        else if (w_v_next == w_eff[I_VS_END][VW-1:0]) r_vs <= 1'b0;
      end
      if (w_commit) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_hinit   = (r_h == r_active[I_HCNT_END][HW-1:0]);
  assign Hinit     = w_hinit;
  assign Vinit     = w_hinit && (r_vdump == r_active[I_VCNT_END][VW-1:0]);
  assign vrender   = w_v_wrap ? r_active[I_VCNT_START][VW-1:0] : r_vdump + VW'(1);
  assign H         = r_h;
  assign vdump     = r_vdump;
  assign hf        = r_h ^ {HW{flip}};
  assign vf        = r_vdump ^ {VW{flip}};
  assign LHBL      = r_lhbl;
  assign LVBL      = r_lvbl;
  assign HS        = r_hs;
  assign VS        = r_vs;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_jtframe_vtimer_prog.sv
// Self-checking bench for jtframe_vtimer_prog with a short 22-line frame.
module tb_jtframe_vtimer_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       flip = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_sel = 4'd0;
  logic [8:0] cfg_data = 9'd0;
  logic [8:0] H, vdump, vrender, hf, vf;
  logic       Hinit, Vinit, LHBL, LVBL, HS, VS;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  jtframe_vtimer_prog #(
    .VCNT_END(21), .VB_START(18), .VB_END(2), .VS_START(19), .VS_END(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .H(H), .vdump(vdump), .vrender(vrender), .hf(hf), .vf(vf),
    .Hinit(Hinit), .Vinit(Vinit), .LHBL(LHBL), .LVBL(LVBL),
    .HS(HS), .VS(VS), .frame_cnt(frame_cnt)
  );

  localparam int FRAME = 22 * 384;
  localparam logic [58:0] RESET_VEC = {9'd0, 9'd0, 9'd1, 9'd0, 9'd0,
                                       6'b000000, 8'd0};

  wire [58:0] dut_vec = {H, vdump, vrender, hf, vf, Hinit, Vinit,
                         LHBL, LVBL, HS, VS, frame_cnt};

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  int m_init [12] = '{0, 383, 256, 16, 304, 336, 0, 21, 18, 2, 19, 20};
  int m_act  [12];
  int m_sh   [12];
  int m_h, m_v, m_fc;
  bit m_lhbl, m_lvbl, m_hs, m_vs;

  task automatic model_reset();
    m_act = m_init;
    m_sh  = m_init;
    m_h = m_init[0];
    m_v = m_init[6];
    m_fc = 0;
    m_lhbl = 0; m_lvbl = 0; m_hs = 0; m_vs = 0;
  endtask

  // One clock edge: positions advance per pixel; a frame end adopts the
  // pending geometry before any edge is judged; writes land afterwards.
  task automatic model_step(bit cen, bit we, int sel, int data);
    int cfg [12];
    bit eol, eof;
    int nh, nv;
    if (cen) begin
      eol = (m_h == m_act[1]) || (m_h == 511);
      eof = eol && ((m_v == m_act[7]) || (m_v == 511));
      if (eof) cfg = m_sh; else cfg = m_act;
      nh = eol ? cfg[0] : m_h + 1;
      nv = !eol ? m_v : (eof ? cfg[6] : m_v + 1);
      if (nh == cfg[2]) m_lhbl = 0; else if (nh == cfg[3]) m_lhbl = 1;
      if (nh == cfg[4]) m_hs = 1;   else if (nh == cfg[5]) m_hs = 0;
      if (eol) begin
        if (nv == cfg[8]) m_lvbl = 0; else if (nv == cfg[9]) m_lvbl = 1;
      end
      if (nh == cfg[4]) begin
        if (nv == cfg[10]) m_vs = 1; else if (nv == cfg[11]) m_vs = 0;
      end
      if (eof) begin
        m_act = m_sh;
        m_fc = (m_fc + 1) % 256;
      end
      m_h = nh;
      m_v = nv;
    end
    if (we && sel < 12) m_sh[sel] = data % 512;
  endtask

  function automatic logic [58:0] exp_vec();
    int  vr;
    bit  hi, vi;
    int  fm;
    vr = ((m_v == m_act[7]) || (m_v == 511)) ? m_act[6] : m_v + 1;
    hi = (m_h == m_act[1]);
    vi = hi && (m_v == m_act[7]);
    fm = flip ? 511 : 0;
    return {9'(m_h), 9'(m_v), 9'(vr), 9'(m_h ^ fm), 9'(m_v ^ fm),
            hi, vi, m_lhbl, m_lvbl, m_hs, m_vs, 8'(m_fc)};
  endfunction

  // Drive one clock worth of inputs, advance the model, return at negedge
  task automatic tick(bit cen, bit we = 0, int sel = 0, int data = 0);
    pxl_cen  = cen;
    cfg_we   = we;
    cfg_sel  = 4'(sel);
    cfg_data = 9'(data);
    @(posedge clk);
    model_step(cen, we, sel, data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_defaults();
    int pos = 0, last_hi = -1, f1_pos = -1;
    int lhbl_low = 0, hs_hi = 0, lvbl_low_lines = 0, vs_states = 0;
    for (int i = 0; i < 2 * FRAME + 800; i++) begin
      tick(bit'(i % 2));
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL defaults_cycle got=%h exp=%h", dut_vec, exp_vec());
      end
      if (i % 2 == 1) begin
        pos++;
        if (vdump == 9'd1 && frame_cnt == 8'd0) begin
          if (!LHBL) lhbl_low++;
          if (HS) hs_hi++;
        end
        if (frame_cnt == 8'd0 && VS) vs_states++;
        if (Hinit && frame_cnt == 8'd0 && !LVBL) lvbl_low_lines++;
        if (Hinit) begin
          if (last_hi >= 0) begin
            total++;
            if (pos - last_hi != 384) begin
              bad++;
              $display("FAIL hinit_period got=%0d exp=384", pos - last_hi);
            end
          end
          last_hi = pos;
        end
        if (frame_cnt == 8'd1 && f1_pos < 0) f1_pos = pos;
      end
    end
    total++;
    if (f1_pos != FRAME) begin
      bad++; $display("FAIL first_frame_pos got=%0d exp=%0d", f1_pos, FRAME);
    end
    total++;
    if (lhbl_low != 144) begin
      bad++; $display("FAIL lhbl_low_px got=%0d exp=144", lhbl_low);
    end
    total++;
    if (hs_hi != 32) begin
      bad++; $display("FAIL hs_high_px got=%0d exp=32", hs_hi);
    end
    total++;
    if (lvbl_low_lines != 6) begin
      bad++; $display("FAIL lvbl_low_lines got=%0d exp=6", lvbl_low_lines);
    end
    total++;
    if (vs_states != 384) begin
      bad++; $display("FAIL vs_high_px got=%0d exp=384", vs_states);
    end
  endtask

  task automatic test_flip();
    bit found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick(1'b1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL flip_run got=%h exp=%h", dut_vec, exp_vec());
      end
      if (m_h == 5 && m_v == 20) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL flip_reach got=0 exp=1");
    end
    flip = 1'b1;
    #1;
    total++;
    if ({hf, vf} !== {9'h1FA, 9'h1EB}) begin
      bad++; $display("FAIL flip_on got=%h/%h exp=1fa/1eb", hf, vf);
    end
    flip = 1'b0;
    #1;
    total++;
    if ({hf, vf} !== {9'd5, 9'd20}) begin
      bad++; $display("FAIL flip_off got=%h/%h exp=005/014", hf, vf);
    end
  endtask

  task automatic test_program();
    int pos = 0, last_hi = -1, f4_lines = 0, exp_p;
    bit sim_done = 0;
    tick(1'b1, 1'b1, 1, 255);
    for (int i = 0; i < 15000 && f4_lines < 3; i++) begin
      if (!sim_done && m_fc == 2 && m_h == m_act[1] && m_v == m_act[7]) begin
        tick(1'b1, 1'b1, 1, 100);
        sim_done = 1;
      end else begin
        tick(1'b1);
      end
      pos++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL program_cycle got=%h exp=%h", dut_vec, exp_vec());
      end
      if (Hinit) begin
        if (last_hi >= 0) begin
          exp_p = (m_fc == 1) ? 384 : (m_fc <= 3 ? 256 : 101);
          total++;
          if (pos - last_hi != exp_p) begin
            bad++;
            $display("FAIL line_len frame=%0d got=%0d exp=%0d",
                     m_fc, pos - last_hi, exp_p);
          end
        end
        last_hi = pos;
        if (m_fc == 4) f4_lines++;
      end
    end
    total++;
    if (f4_lines < 3) begin
      bad++; $display("FAIL program_reach got=%0d exp=3", f4_lines);
    end
  endtask

  task automatic test_reset_mid();
    int first_hi = -1, second_hi = -1;
    for (int i = 0; i < 50; i++) tick(1'b1);
    tick(1'b1, 1'b1, 1, 50);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec, RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick(1'b1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL after_reset got=%h exp=%h", dut_vec, exp_vec());
      end
      if (Hinit) begin
        if (first_hi < 0) first_hi = i;
        else if (second_hi < 0) second_hi = i;
      end
    end
    total++;
    if (first_hi != 383 || second_hi != 767) begin
      bad++;
      $display("FAIL reset_line_len got=%0d,%0d exp=383,767", first_hi, second_hi);
    end
  endtask

  task automatic test_misprog();
    int wraps = 0;
    logic [8:0] prev_h;
    tick(1'b0, 1'b1, 0, 20);
    tick(1'b0, 1'b1, 1, 10);
    tick(1'b0, 1'b1, 7, 3);
    for (int i = 0; i < FRAME + 100 && m_fc == 0; i++) begin
      tick(1'b1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL misprog_wait got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    total++;
    if (H !== 9'd20 || frame_cnt !== 8'd1) begin
      bad++; $display("FAIL misprog_start got=%0d/%0d exp=20/1", H, frame_cnt);
    end
    prev_h = H;
    for (int i = 0; i < 1200; i++) begin
      tick(1'b1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL misprog_cycle got=%h exp=%h", dut_vec, exp_vec());
      end
      if (prev_h == 9'd511 && H == 9'd20) wraps++;
      prev_h = H;
    end
    total++;
    if (wraps != 2) begin
      bad++; $display("FAIL misprog_wraps got=%0d exp=2", wraps);
    end
  endtask

  task automatic test_random();
    bit cen, we;
    int sel, data;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom % 64 == 0) flip = ~flip;
      cen  = ($urandom % 4) != 0;
      we   = ($urandom % 24) == 0;
      sel  = int'($urandom % 16);
      data = int'($urandom_range(0, 63));
      tick(cen, we, sel, data);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random_cycle got=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_flip();
    test_program();
    test_reset_mid();
    test_misprog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
